// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift/serializer datapath.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam bit DIR_MSB_FIRST = 1'b1;
  localparam bit DIR_LSB_FIRST = 1'b0;

  // Bit-count width; one extra bit so WIDTH itself is representable.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/out_buffer.sv
// One-entry valid/ready output register with load, drain, overrun and clear.
module out_buffer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic free;

  // A word being drained this cycle frees the slot for a simultaneous load.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      if (free) begin
        data  <= load_data;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: shifts one bit per strobe into a word
// and hands completed words to a one-entry valid/ready buffer.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = DIR_MSB_FIRST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic                      s_bit,
  input  logic                      clear,
  output logic [WIDTH-1:0]          m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy,
  output logic                      overrun,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic             complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], s_bit}
                              : {s_bit, sr_q[WIDTH-1:1]};

  // clear wins over an offered bit; the bit counter wraps explicitly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    complete = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (s_valid) begin
      sr_d = sr_shift;
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          cnt_d   = CW'(1);
        end
        SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bit_cnt = cnt_q;
  assign busy    = (cnt_q != '0);

  out_buffer #(
    .WIDTH(WIDTH)
  ) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (complete),
    .load_data (sr_shift),
    .ready     (m_ready),
    .data      (m_data),
    .valid     (m_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_bit, clear, m_ready;
  logic [3:0] data_m, data_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .clear(clear),
    .m_data(data_m), .m_valid(valid_m), .m_ready(m_ready),
    .busy(busy_m), .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  shift_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .clear(clear),
    .m_data(data_l), .m_valid(valid_l), .m_ready(m_ready),
    .busy(busy_l), .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  typedef struct {
    logic       v, b, rdy, clr;
    logic [3:0] em, el;
    logic       ev;
    logic [2:0] ec;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] em, input logic [3:0] el,
                           input logic ev, input logic [2:0] ec, input logic eo);
    check({tag, " data_m"},  32'(data_m),  32'(em));
    check({tag, " data_l"},  32'(data_l),  32'(el));
    check({tag, " valid_m"}, 32'(valid_m), 32'(ev));
    check({tag, " valid_l"}, 32'(valid_l), 32'(ev));
    check({tag, " cnt_m"},   32'(cnt_m),   32'(ec));
    check({tag, " cnt_l"},   32'(cnt_l),   32'(ec));
    check({tag, " busy_m"},  32'(busy_m),  32'(ec != 3'd0));
    check({tag, " busy_l"},  32'(busy_l),  32'(ec != 3'd0));
    check({tag, " ovr_m"},   32'(ovr_m),   32'(eo));
    check({tag, " ovr_l"},   32'(ovr_l),   32'(eo));
  endtask

  // Apply inputs, take one rising edge, settle just past it.
  task automatic step(input logic v, input logic b, input logic rdy, input logic clr);
    s_valid = v;
    s_bit   = b;
    m_ready = rdy;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic b, input logic rdy, input logic clr,
                              input logic [3:0] em, input logic [3:0] el, input logic ev,
                              input logic [2:0] ec, input logic eo);
    vec_t r;
    r.v = v; r.b = b; r.rdy = rdy; r.clr = clr;
    r.em = em; r.el = el; r.ev = ev; r.ec = ec; r.eo = eo;
    vecs.push_back(r);
  endfunction

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; clear = 1'b0; m_ready = 1'b0;

    // Words 1,0,1,1 back to back, then again with 3-cycle gaps.
    add(1, 1, 1, 0, 4'h0, 4'h0, 0, 3'd1, 0);
    add(1, 0, 1, 0, 4'h0, 4'h0, 0, 3'd2, 0);
    add(1, 1, 1, 0, 4'h0, 4'h0, 0, 3'd3, 0);
    add(1, 1, 1, 0, 4'hB, 4'hD, 1, 3'd0, 0);
    add(0, 0, 1, 0, 4'hB, 4'hD, 0, 3'd0, 0);
    add(1, 1, 1, 0, 4'hB, 4'hD, 0, 3'd1, 0);
    for (int g = 0; g < 3; g++) add(0, 0, 1, 0, 4'hB, 4'hD, 0, 3'd1, 0);
    add(1, 0, 1, 0, 4'hB, 4'hD, 0, 3'd2, 0);
    for (int g = 0; g < 3; g++) add(0, 1, 1, 0, 4'hB, 4'hD, 0, 3'd2, 0);
    add(1, 1, 1, 0, 4'hB, 4'hD, 0, 3'd3, 0);
    for (int g = 0; g < 3; g++) add(0, 0, 1, 0, 4'hB, 4'hD, 0, 3'd3, 0);
    add(1, 1, 1, 0, 4'hB, 4'hD, 1, 3'd0, 0);
    add(0, 0, 1, 0, 4'hB, 4'hD, 0, 3'd0, 0);

    @(posedge clk);
    #1;
    check_all("reset", 4'h0, 4'h0, 0, 3'd0, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].b, vecs[i].rdy, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].em, vecs[i].el, vecs[i].ev, vecs[i].ec, vecs[i].eo);
    end

    // Overrun: 0110 buffered with m_ready low, then 1111 is dropped.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    check_all("ovr_first", 4'h6, 4'h6, 1, 3'd0, 0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    check_all("ovr_pre", 4'h6, 4'h6, 1, 3'd3, 0);
    step(1, 1, 0, 0);
    check_all("ovr_set", 4'h6, 4'h6, 1, 3'd0, 1);
    step(0, 0, 1, 0);
    check_all("ovr_drain", 4'h6, 4'h6, 0, 3'd0, 1);
    step(0, 0, 0, 1);
    check_all("ovr_clear", 4'h6, 4'h6, 0, 3'd0, 0);

    // Back-to-back 0110 then 1001; drain coincides with the second completion.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    check_all("b2b_first", 4'h6, 4'h6, 1, 3'd0, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    check_all("b2b_hold", 4'h6, 4'h6, 1, 3'd3, 0);
    step(1, 1, 1, 0);
    check_all("b2b_swap", 4'h9, 4'h9, 1, 3'd0, 0);
    step(0, 0, 0, 0);
    check_all("b2b_stall", 4'h9, 4'h9, 1, 3'd0, 0);
    step(0, 0, 1, 0);
    check_all("b2b_drain", 4'h9, 4'h9, 0, 3'd0, 0);

    // clear after 2 bits discards them and the bit offered alongside it.
    step(1, 1, 1, 0); step(1, 1, 1, 0);
    check_all("clr_pre", 4'h9, 4'h9, 0, 3'd2, 0);
    step(1, 1, 1, 1);
    check_all("clr_hit", 4'h9, 4'h9, 0, 3'd0, 0);
    step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    check_all("clr_word", 4'h3, 4'hC, 1, 3'd0, 0);
    step(0, 0, 1, 0);
    check_all("clr_drain", 4'h3, 4'hC, 0, 3'd0, 0);

    // clear on the would-be completing bit suppresses the word.
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    check_all("clr_last", 4'h3, 4'hC, 0, 3'd0, 0);

    // Async reset mid-word, between clock edges.
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0);
    check_all("rst_pre", 4'h3, 4'hC, 0, 3'd3, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_async", 4'h0, 4'h0, 0, 3'd0, 0);
    rst = 1'b0;
    step(1, 1, 1, 0); step(1, 1, 1, 0); step(1, 0, 1, 0);
    check_all("rst_mid", 4'h0, 4'h0, 0, 3'd3, 0);
    step(1, 0, 1, 0);
    check_all("rst_word", 4'hC, 4'h3, 1, 3'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-in, parallel-out receiver. It is the receiving end of the team's shift/serializer datapath: it collects one bit per accepted strobe into a WIDTH-bit shift register. Each completed word goes into a one-entry output buffer with a valid/ready handshake. A sticky flag reports overrun when a completed word cannot be buffered.

Parameters:
WIDTH, 4, word width in bits (≥2)
MSB_FIRST, 1, 1 = first received bit lands in m_data[WIDTH-1]; 0 = first bit lands in m_data[0]

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
s_valid  input  1  serial bit strobe; s_bit accepted on every clk edge where s_valid=1 (no backpressure)
s_bit  input  1  serial data bit
clear  input  1  synchronous abort: drops partial word, empties buffer, clears overrun
m_data  output  WIDTH  assembled word
m_valid  output  1  m_data holds an unread word
m_ready  input  1  consumer accepts m_data when m_valid & m_ready
busy  output  1  partial word in progress (bit count ≠ 0)
overrun  output  1  sticky; a completed word was dropped
bit_cnt  output  $clog2(WIDTH)+1  bits collected in current word (0..WIDTH-1)

Behaviour:
- Async reset, applied any time including mid-word: shift register=0, bit_cnt=0, m_data=0, m_valid=0, busy=0, overrun=0.
- States: IDLE (bit_cnt=0) and SHIFT (0<bit_cnt<WIDTH). IDLE→SHIFT on an accepted bit. SHIFT→IDLE when the WIDTH-th bit is accepted.
- Shift on an accepted bit:
  - MSB_FIRST=1: sr_next = {sr[WIDTH-2:0], s_bit}.
  - MSB_FIRST=0: sr_next = {s_bit, sr[WIDTH-1:1]}.
- Gaps: s_valid=0 holds sr and bit_cnt unchanged for any number of cycles.
- Completion: the edge where bit_cnt=WIDTH-1 and s_valid=1.
  - Buffer free means m_valid=0, or m_valid & m_ready in that same cycle.
  - If free: m_data<=sr_next and m_valid<=1. m_valid is visible 1 cycle after the last bit's edge.
  - If not free: word dropped, overrun<=1, m_data/m_valid unchanged.
  - Either way bit_cnt<=0 and shifting continues with no dead cycle.
- Drain: m_valid & m_ready with no completion in the same cycle sets m_valid<=0. m_data holds its last value.
- Simultaneous drain and completion: new word loaded, m_valid stays 1, no overrun.
- m_data is stable while m_valid=1 and m_ready=0.
- clear=1 (synchronous) has priority over s_valid and completion:
  - sets bit_cnt=0, m_valid=0, overrun=0;
  - leaves sr and m_data unchanged;
  - ignores the bit offered in that cycle.
- overrun stays set until clear or rst.
- busy = (bit_cnt ≠ 0), combinational from the register.
- Counter width: $clog2(WIDTH)+1. Wrap is explicit at WIDTH-1 to 0; never relies on natural overflow.

Decomposition:
- Shared package `shift_pkg`:
  - state enum {IDLE, SHIFT};
  - localparam function cnt_w(WIDTH) = $clog2(WIDTH)+1;
  - direction constants MSB_FIRST/LSB_FIRST.
- One natural sub-module: `out_buffer`, the one-entry valid/ready register. It provides load, drain, full→overrun and clear, and is reusable by a future serializer.
- The shift core stays in the top module.

Test Plan:
- WIDTH=4, MSB_FIRST=1: bits 1,0,1,1 on consecutive cycles with m_ready=1 → m_data=4'b1011, m_valid=1 for one cycle, 1 cycle after 4th bit; busy high during bits 2–4.
- MSB_FIRST=0, same bits → m_data=4'b1101. Repeat with 3-cycle s_valid gaps between bits → identical result, bit_cnt holds during gaps.
- m_ready=0: stream 0,1,1,0 then 1,1,1,1 → m_data stays 4'b0110, overrun=1 after 8th bit. Raise m_ready → m_valid drops next cycle, overrun stays 1.
- Back-to-back words 0110, 1001 with m_ready pulsed on the completion cycle of the second word → m_valid stays 1, m_data=1001, overrun=0.
- After 2 bits, clear=1 with s_valid=1, s_bit=1 → bit_cnt=0, busy=0. Next 4 bits 0,0,1,1 → m_data=0011.
- After 3 bits, assert rst mid-cycle (async) → all outputs 0 immediately, before the next clk edge. Release, send 1,1,0,0 → m_data=1100.
